// File: rtl/i2s_pkg.sv
// i2s_pkg: shared format, channel and FSM definitions for the I2S blocks
package i2s_pkg;
  localparam bit I2S_FMT_I2S = 1'b0;
  localparam bit I2S_FMT_LJ = 1'b1;
  localparam logic CH_LEFT = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
  typedef enum logic [1:0] {
    UNSYNC,
    CAPTURE,
    DONE,
    WAIT
  } i2s_state_e;
endpackage

// File: rtl/i2s_rx_stereo_if.sv
// i2s_rx_stereo_if: codec pins and captured-word outputs of the stereo receiver
interface i2s_rx_stereo_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic lrclk;
  logic sdata_in;
  logic [SAMPLE_WIDTH-1:0] o_audio_data;
  logic o_audio_ch;
  logic o_audio_valid;
  logic o_frame_error;
  modport master (
    output lrclk, sdata_in,
    input o_audio_data, o_audio_ch, o_audio_valid, o_frame_error
  );
  modport slave (
    input lrclk, sdata_in,
    output o_audio_data, o_audio_ch, o_audio_valid, o_frame_error
  );
endinterface

// File: rtl/i2s_lr_edge.sv
// i2s_lr_edge: registers LRCLK and flags word-select edges with the new channel
module i2s_lr_edge
  import i2s_pkg::*;
#(
  parameter bit LEFT_LEVEL = 1'b0
) (
  input  logic bclk,
  input  logic lrclk_i,
  output logic edge_o,
  output logic ch_o
);
  logic lr_q;
  // free-running through reset so releasing reset never looks like an edge
  always_ff @(posedge bclk) lr_q <= lrclk_i;
  assign edge_o = lrclk_i != lr_q;
  assign ch_o = (lrclk_i != LEFT_LEVEL) ? CH_RIGHT : CH_LEFT;
endmodule

// File: rtl/i2s_rx_stereo.sv
// i2s_rx_stereo: stereo I2S / left-justified receiver running on the bit clock
module i2s_rx_stereo
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter bit FORMAT = I2S_FMT_I2S,
  parameter bit LEFT_LEVEL = 1'b0
) (
  input logic bclk,
  input logic reset,
  i2s_rx_stereo_if.slave bus
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_WIDTH);
  localparam logic [CW-1:0] CNT_START = (FORMAT == I2S_FMT_LJ) ? CW'(1) : CW'(0);
  i2s_state_e state_q;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] sr_q, sr_d, data_q;
  logic ch_q, out_ch_q, valid_q, err_q, lr_edge, lr_ch;
  i2s_lr_edge #(.LEFT_LEVEL(LEFT_LEVEL)) u_lr_edge (
    .bclk(bclk),
    .lrclk_i(bus.lrclk),
    .edge_o(lr_edge),
    .ch_o(lr_ch)
  );
  // left-justified slots already carry the new MSB on the edge cycle
  always_comb begin
    sr_d = {sr_q[SAMPLE_WIDTH-2:0], bus.sdata_in};
    bit_cnt_d = lr_edge ? CNT_START : (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CW'(1);
  end
  always_ff @(posedge bclk) begin
    if (!reset) begin
      state_q <= UNSYNC;
      bit_cnt_q <= '0;
      sr_q <= '0;
      ch_q <= CH_LEFT;
      data_q <= '0;
      out_ch_q <= CH_LEFT;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      valid_q <= state_q == DONE;
      err_q <= lr_edge && state_q == CAPTURE && bit_cnt_q < CNT_MAX;
      if (state_q == DONE) begin
        data_q <= sr_q;
        out_ch_q <= ch_q;
      end
      if (lr_edge) begin
        state_q <= CAPTURE;
        ch_q <= lr_ch;
        sr_q <= sr_d;
        bit_cnt_q <= bit_cnt_d;
      end else if (state_q == CAPTURE) begin
        sr_q <= sr_d;
        bit_cnt_q <= bit_cnt_d;
        state_q <= (bit_cnt_q == CNT_LAST) ? DONE : CAPTURE;
      end else if (state_q == DONE) begin
        state_q <= WAIT;
      end
    end
  end
  assign bus.o_audio_data = data_q;
  assign bus.o_audio_ch = out_ch_q;
  assign bus.o_audio_valid = valid_q;
  assign bus.o_frame_error = err_q;
endmodule

// File: tb/tb_i2s_rx_stereo.sv
// tb_i2s_rx_stereo: directed bench over I2S, left-justified and 16-bit/inverted-LR receivers
module tb_i2s_rx_stereo;
  import i2s_pkg::*;
  typedef struct {
    int d;
    int cyc;
    logic [31:0] data;
    logic ch;
    logic v;
    logic e;
  } ev_t;
  logic bclk = 1'b0;
  logic rst = 1'b0;
  logic lr [3];
  logic sd [3];
  logic [31:0] od [3];
  logic oc [3];
  logic ov [3];
  logic oe [3];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  ev_t evq [$];
  i2s_rx_stereo_if #(.SAMPLE_WIDTH(24)) if0 ();
  i2s_rx_stereo_if #(.SAMPLE_WIDTH(24)) if1 ();
  i2s_rx_stereo_if #(.SAMPLE_WIDTH(16)) if2 ();
  i2s_rx_stereo #(.SAMPLE_WIDTH(24), .FORMAT(I2S_FMT_I2S), .LEFT_LEVEL(1'b0)) u0 (
    .bclk(bclk), .reset(rst), .bus(if0));
  i2s_rx_stereo #(.SAMPLE_WIDTH(24), .FORMAT(I2S_FMT_LJ), .LEFT_LEVEL(1'b0)) u1 (
    .bclk(bclk), .reset(rst), .bus(if1));
  i2s_rx_stereo #(.SAMPLE_WIDTH(16), .FORMAT(I2S_FMT_I2S), .LEFT_LEVEL(1'b1)) u2 (
    .bclk(bclk), .reset(rst), .bus(if2));
  assign if0.lrclk = lr[0];
  assign if0.sdata_in = sd[0];
  assign if1.lrclk = lr[1];
  assign if1.sdata_in = sd[1];
  assign if2.lrclk = lr[2];
  assign if2.sdata_in = sd[2];
  assign od[0] = 32'(if0.o_audio_data);
  assign od[1] = 32'(if1.o_audio_data);
  assign od[2] = 32'(if2.o_audio_data);
  assign oc[0] = if0.o_audio_ch;
  assign oc[1] = if1.o_audio_ch;
  assign oc[2] = if2.o_audio_ch;
  assign ov[0] = if0.o_audio_valid;
  assign ov[1] = if1.o_audio_valid;
  assign ov[2] = if2.o_audio_valid;
  assign oe[0] = if0.o_frame_error;
  assign oe[1] = if1.o_frame_error;
  assign oe[2] = if2.o_frame_error;

  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  // cyc seen here is the index of the rising edge that produced the outputs
  always @(negedge bclk) begin : mon
    ev_t e;
    for (int d = 0; d < 3; d++)
      if (ov[d] === 1'b1 || oe[d] === 1'b1) begin
        e.d = d;
        e.cyc = cyc;
        e.data = od[d];
        e.ch = oc[d];
        e.v = ov[d];
        e.e = oe[d];
        evq.push_back(e);
      end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_ev(input string tag, input int i, input int d, input int c,
                        input logic [31:0] data, input logic ch, input logic e);
    chk({tag, "_present"}, 64'(evq.size() > i), 64'd1);
    if (evq.size() > i) begin
      chk({tag, "_dut"}, 64'(evq[i].d), 64'(d));
      chk({tag, "_cyc"}, 64'(evq[i].cyc), 64'(c));
      chk({tag, "_valid"}, 64'(evq[i].v), 64'(!e));
      chk({tag, "_err"}, 64'(evq[i].e), 64'(e));
      if (!e) begin
        chk({tag, "_data"}, 64'(evq[i].data), 64'(data));
        chk({tag, "_ch"}, 64'(evq[i].ch), 64'(ch));
      end
    end
  endtask

  // j = 0 is the cycle carrying the new LRCLK level; k is the rising edge that samples it
  task automatic send_slot(input int d, input logic lv, input logic [31:0] word, input int w,
                           input int len, input bit lj, input int rst_at, output int k);
    int bi;
    k = 0;
    for (int j = 0; j < len; j++) begin
      @(negedge bclk);
      if (j == 0) k = cyc + 1;
      bi = lj ? j : j - 1;
      lr[d] = lv;
      sd[d] = (bi >= 0 && bi < w) ? word[w-1-bi] : 1'b1;
      if (rst_at >= 0) rst = !(bi >= rst_at && bi < rst_at + 2);
    end
  endtask

  initial begin
    int k, k2, k3;
    for (int d = 0; d < 3; d++) begin
      lr[d] = 1'b1;
      sd[d] = 1'b0;
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge bclk);
      for (int d = 0; d < 3; d++) begin
        lr[d] = (i % 2 == 1) ? 1'b0 : 1'b1;
        sd[d] = 1'($urandom_range(1));
      end
    end
    @(negedge bclk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge bclk);
      for (int d = 0; d < 3; d++) sd[d] = 1'($urandom_range(1));
    end
    chk("rst_events", 64'(evq.size()), 64'd0);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_data%0d", d), 64'(od[d]), 64'd0);
      chk($sformatf("rst_ch%0d", d), 64'(oc[d]), 64'd0);
      chk($sformatf("rst_valid%0d", d), 64'(ov[d]), 64'd0);
      chk($sformatf("rst_err%0d", d), 64'(oe[d]), 64'd0);
    end

    evq.delete();
    send_slot(0, 1'b0, 32'hACE123, 24, 32, 1'b0, -1, k);
    send_slot(0, 1'b1, 32'h5A5A5A, 24, 32, 1'b0, -1, k2);
    repeat (4) @(negedge bclk);
    chk("i2s_count", 64'(evq.size()), 64'd2);
    exp_ev("i2s_left", 0, 0, k + 25, 32'hACE123, CH_LEFT, 1'b0);
    exp_ev("i2s_right", 1, 0, k2 + 25, 32'h5A5A5A, CH_RIGHT, 1'b0);
    chk("i2s_hold_data", 64'(od[0]), 64'h5A5A5A);
    chk("i2s_hold_ch", 64'(oc[0]), 64'd1);

    evq.delete();
    send_slot(1, 1'b0, 32'hACE123, 24, 32, 1'b1, -1, k);
    send_slot(1, 1'b1, 32'h5A5A5A, 24, 24, 1'b1, -1, k2);
    send_slot(1, 1'b0, 32'h00FF00, 24, 32, 1'b1, -1, k3);
    repeat (4) @(negedge bclk);
    chk("lj_count", 64'(evq.size()), 64'd3);
    exp_ev("lj_left", 0, 1, k + 24, 32'hACE123, CH_LEFT, 1'b0);
    exp_ev("lj_right_min", 1, 1, k2 + 24, 32'h5A5A5A, CH_RIGHT, 1'b0);
    exp_ev("lj_left2", 2, 1, k3 + 24, 32'h00FF00, CH_LEFT, 1'b0);

    evq.delete();
    send_slot(0, 1'b0, 32'h123456, 24, 17, 1'b0, -1, k);
    send_slot(0, 1'b1, 32'h0F1E2D, 24, 32, 1'b0, -1, k2);
    repeat (4) @(negedge bclk);
    chk("short_count", 64'(evq.size()), 64'd2);
    exp_ev("short_err", 0, 0, k + 17, 32'h0, CH_LEFT, 1'b1);
    exp_ev("short_next", 1, 0, k2 + 25, 32'h0F1E2D, CH_RIGHT, 1'b0);

    evq.delete();
    send_slot(0, 1'b0, 32'h777777, 24, 32, 1'b0, 10, k);
    send_slot(0, 1'b1, 32'h13579B, 24, 32, 1'b0, -1, k2);
    repeat (4) @(negedge bclk);
    chk("rstmid_count", 64'(evq.size()), 64'd1);
    exp_ev("rstmid_next", 0, 0, k2 + 25, 32'h13579B, CH_RIGHT, 1'b0);

    evq.delete();
    send_slot(2, 1'b0, 32'hBEEF, 16, 32, 1'b0, -1, k);
    send_slot(2, 1'b1, 32'h1234, 16, 17, 1'b0, -1, k2);
    send_slot(2, 1'b0, 32'hC3A5, 16, 32, 1'b0, -1, k3);
    repeat (4) @(negedge bclk);
    chk("w16_count", 64'(evq.size()), 64'd3);
    exp_ev("w16_right", 0, 2, k + 17, 32'hBEEF, CH_RIGHT, 1'b0);
    exp_ev("w16_left_min", 1, 2, k2 + 17, 32'h1234, CH_LEFT, 1'b0);
    exp_ev("w16_right2", 2, 2, k3 + 17, 32'hC3A5, CH_RIGHT, 1'b0);
    chk("w16_hold_data", 64'(od[2]), 64'hC3A5);
    chk("w16_hold_valid", 64'(ov[2]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
